// File: rtl/regbus_master_if.sv
// ----------------------------------------------------------------------------
// regbus_master_if
// Command/response handshake between the command layer and regbus_master.
//   cmd_valid/cmd_ready  : command handshake (periph, addr, rw, wdata)
//   rsp_valid/rsp_ready  : response handshake (data, size, error)
// Modports:
//   master : the view seen by regbus_master (consumes commands, produces responses)
//   slave  : the view seen by the command layer
// ----------------------------------------------------------------------------
interface regbus_master_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [3:0]  cmd_periph;
   logic [7:0]  cmd_addr;
   logic        cmd_rw;
   logic [31:0] cmd_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic [2:0]  rsp_size;
   logic        rsp_error;

   modport master (
      input  cmd_valid, cmd_periph, cmd_addr, cmd_rw, cmd_wdata, rsp_ready,
      output cmd_ready, rsp_valid, rsp_data, rsp_size, rsp_error
   );

   modport slave (
      output cmd_valid, cmd_periph, cmd_addr, cmd_rw, cmd_wdata, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_data, rsp_size, rsp_error
   );
endinterface

// File: rtl/regbus_master.sv
// ----------------------------------------------------------------------------
// regbus_master
// Initiator for the shared peripheral register bus. Accepts one register
// read/write command, runs a single SETUP / STROBE / RELEASE transaction on
// the selected peripheral and returns read data, register size and error.
//
// Parameters:
//   NUM_PERIPH  : number of one-hot select lines (1..16)
//   HOLD_CYCLES : cycles select stays high per transaction (clamped to >= 2)
// Optional build macro:
//   REGBUS_MASTER_SIZEMASK_EN : mask captured read data to rsp_size bytes
// Ports:
//   clk_12MHz     : clock, rising edge
//   resetn        : synchronous active-low reset
//   cmd_if        : command/response handshake (regbus_master_if.master)
//   databus       : shared data bus, driven only during write transactions
//   reg_size      : register size reported by the selected peripheral
//   register_addr : register address to peripherals
//   rw            : bus direction, 0 = write, 1 = read (1 whenever idle)
//   select        : one-hot peripheral select
// ----------------------------------------------------------------------------
module regbus_master #(
   parameter int NUM_PERIPH  = 8,
   parameter int HOLD_CYCLES = 3
) (
   input  logic                  clk_12MHz,
   input  logic                  resetn,
   regbus_master_if.master       cmd_if,
   inout  wire  [31:0]           databus,
   input  logic [2:0]            reg_size,
   output logic [7:0]            register_addr,
   output logic                  rw,
   output logic [NUM_PERIPH-1:0] select
);

   localparam int HOLD = (HOLD_CYCLES < 2) ? 2 : HOLD_CYCLES;
   localparam int CW   = $clog2(HOLD);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_STROBE,
      S_RELEASE,
      S_RESP
   } state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [3:0]            periph_q, periph_d;
   logic [7:0]            addr_q, addr_d;
   logic                  rw_q, rw_d;          // latched command direction
   logic [31:0]           wdata_q, wdata_d;
   logic [31:0]           rdata_q, rdata_d;
   logic [2:0]            size_q, size_d;
   logic                  err_q, err_d;
   // Bus-facing outputs are registered so select/rw/databus enable never glitch.
   logic [NUM_PERIPH-1:0] sel_q, sel_d;
   logic                  bus_rw_q, bus_rw_d;
   logic                  drv_q, drv_d;
   logic [NUM_PERIPH-1:0] onehot;

`ifdef REGBUS_MASTER_SIZEMASK_EN
   function automatic logic [31:0] size_mask(input logic [31:0] d, input logic [2:0] sz);
      case (sz)
         3'd0:    size_mask = 32'h0;
         3'd1:    size_mask = {24'h0, d[7:0]};
         3'd2:    size_mask = {16'h0, d[15:0]};
         3'd3:    size_mask = {8'h0, d[23:0]};
         default: size_mask = d;
      endcase
   endfunction
`endif

   always_comb begin
      for (int i = 0; i < NUM_PERIPH; i++) begin
         onehot[i] = (periph_q == 4'(i));
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      periph_d = periph_q;
      addr_d   = addr_q;
      rw_d     = rw_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      size_d   = size_q;
      err_d    = err_q;
      sel_d    = '0;
      bus_rw_d = 1'b1;
      drv_d    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (cmd_if.cmd_valid) begin
               periph_d = cmd_if.cmd_periph;
               addr_d   = cmd_if.cmd_addr;
               rw_d     = cmd_if.cmd_rw;
               wdata_d  = cmd_if.cmd_wdata;
               if (int'(cmd_if.cmd_periph) >= NUM_PERIPH) begin
                  // Nobody to talk to: answer at once without touching the bus.
                  state_d = S_RESP;
                  rdata_d = 32'h0;
                  size_d  = 3'd0;
                  err_d   = 1'b1;
               end else begin
                  state_d  = S_SETUP;
                  bus_rw_d = cmd_if.cmd_rw;
                  drv_d    = ~cmd_if.cmd_rw;
               end
            end
         end
         S_SETUP: begin
            state_d  = S_STROBE;
            cnt_d    = '0;
            sel_d    = onehot;
            bus_rw_d = rw_q;
            drv_d    = ~rw_q;
         end
         S_STROBE: begin
            // Direction and write data stay on the bus through RELEASE.
            bus_rw_d = rw_q;
            drv_d    = ~rw_q;
            if (cnt_q == CW'(HOLD - 1)) begin
               state_d = S_RELEASE;
               size_d  = reg_size;
               err_d   = (reg_size == 3'd0);
`ifdef REGBUS_MASTER_SIZEMASK_EN
               rdata_d = rw_q ? size_mask(databus, reg_size) : 32'h0;
`else
               rdata_d = rw_q ? databus : 32'h0;
`endif
            end else begin
               cnt_d = cnt_q + 1'b1;
               sel_d = onehot;
            end
         end
         S_RELEASE: begin
            state_d = S_RESP;
         end
         S_RESP: begin
            if (cmd_if.rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_12MHz) begin
      if (!resetn) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         periph_q <= 4'h0;
         addr_q   <= 8'h0;
         rw_q     <= 1'b1;
         wdata_q  <= 32'h0;
         rdata_q  <= 32'h0;
         size_q   <= 3'd0;
         err_q    <= 1'b0;
         sel_q    <= '0;
         bus_rw_q <= 1'b1;
         drv_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         periph_q <= periph_d;
         addr_q   <= addr_d;
         rw_q     <= rw_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         size_q   <= size_d;
         err_q    <= err_d;
         sel_q    <= sel_d;
         bus_rw_q <= bus_rw_d;
         drv_q    <= drv_d;
      end
   end

   // drv_q is only ever set together with bus_rw_q = 0.
   assign databus       = drv_q ? wdata_q : {32{1'bz}};
   assign register_addr = addr_q;
   assign rw            = bus_rw_q;
   assign select        = sel_q;

   assign cmd_if.cmd_ready = (state_q == S_IDLE);
   assign cmd_if.rsp_valid = (state_q == S_RESP);
   assign cmd_if.rsp_data  = rdata_q;
   assign cmd_if.rsp_size  = size_q;
   assign cmd_if.rsp_error = err_q;

endmodule

// File: tb/tb_regbus_master.sv
// ----------------------------------------------------------------------------
// tb_regbus_master
// Directed bench for regbus_master with a small peripheral model and an
// in-order scoreboard. Stimulus pushes expected responses; a monitor on the
// falling edge pops and compares whenever rsp_valid rises, and checks the bus
// (select width/gap, address, direction, write data) against the in-flight item.
// ----------------------------------------------------------------------------
module tb_regbus_master;
   localparam int NP = 8;

   logic        clk_12MHz = 1'b0;
   logic        resetn;
   wire  [31:0] databus;
   logic [2:0]  reg_size;
   logic [7:0]  register_addr;
   logic        rw;
   logic [NP-1:0] select;

   regbus_master_if bus_if();

   regbus_master #(.NUM_PERIPH(NP), .HOLD_CYCLES(3)) dut (
      .clk_12MHz     (clk_12MHz),
      .resetn        (resetn),
      .cmd_if        (bus_if),
      .databus       (databus),
      .reg_size      (reg_size),
      .register_addr (register_addr),
      .rw            (rw),
      .select        (select)
   );

   always #5 clk_12MHz = ~clk_12MHz;

   int cyc = 0;
   always @(posedge clk_12MHz) cyc++;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- peripheral model ----------------
   logic [7:0]  p2_mem [256];
   logic [31:0] p5_mem [256];
   logic [31:0] per_dout;
   logic        per_drv;

   always_comb begin
      reg_size = 3'd0;
      per_dout = 32'h0;
      if (select[0]) begin
         reg_size = (register_addr == 8'd9) ? 3'd0 : 3'd4;
      end else if (select[2]) begin
         reg_size = 3'd1;
         per_dout = {24'h0, p2_mem[register_addr]};
      end else if (select[3]) begin
         if (register_addr == 8'h10) begin
            reg_size = 3'd2;
            per_dout = 32'hDEADBEEF;
         end
      end else if (select[5]) begin
         reg_size = 3'd4;
         per_dout = p5_mem[register_addr];
      end
   end

   assign per_drv = (|select) && rw;
   assign databus = per_drv ? per_dout : {32{1'bz}};

   always @(posedge clk_12MHz) begin
      if (!rw && select[2]) p2_mem[register_addr] <= databus[7:0];
      if (!rw && select[5]) p5_mem[register_addr] <= databus;
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      logic [31:0] data;
      logic [2:0]  size;
      logic        err;
      int          lat;
      int          acc;
      int          periph;
      logic [7:0]  addr;
      logic        rwr;
      logic [31:0] wdata;
   } exp_t;

   exp_t exp_q[$];

   logic        mon_en = 1'b0;
   logic        abort = 1'b0;
   logic        prev_v = 1'b0;
   logic [35:0] held;
   int          run = 0;
   int          gap = 0;
   logic        seen_strobe = 1'b0;
   int          strobe_cnt = 0;

   always @(negedge clk_12MHz) begin
      if (mon_en) begin
         // response path
         if (bus_if.rsp_valid) begin
            if (!prev_v) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_rsp", 32'd1, 32'd0);
               end else begin
                  exp_t e;
                  e = exp_q.pop_front();
                  chk("rsp_data", bus_if.rsp_data, e.data);
                  chk("rsp_size", 32'(bus_if.rsp_size), 32'(e.size));
                  chk("rsp_error", 32'(bus_if.rsp_error), 32'(e.err));
                  chk("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
               end
               held = {bus_if.rsp_error, bus_if.rsp_size, bus_if.rsp_data};
            end else begin
               chk("rsp_stable", 32'({bus_if.rsp_error, bus_if.rsp_size, bus_if.rsp_data} == held), 32'd1);
               chk("cmd_ready_in_resp", 32'(bus_if.cmd_ready), 32'd0);
            end
         end
         prev_v = bus_if.rsp_valid && !bus_if.rsp_ready;

         // bus path
         if (select != '0) begin
            if (run == 0) begin
               if (seen_strobe) chk("sel_gap_ge2", 32'(gap >= 2), 32'd1);
               seen_strobe = 1'b1;
               strobe_cnt++;
            end
            run++;
            gap = 0;
            if (exp_q.size() == 0) begin
               chk("strobe_without_cmd", 32'd1, 32'd0);
            end else begin
               logic [NP-1:0] es;
               es = NP'(1) << exp_q[0].periph;
               chk("select_onehot", 32'(select), 32'(es));
               chk("strobe_addr", 32'(register_addr), 32'(exp_q[0].addr));
               chk("strobe_rw", 32'(rw), 32'(exp_q[0].rwr));
               if (!exp_q[0].rwr) chk("strobe_wdata", databus, exp_q[0].wdata);
            end
         end else begin
            if (run > 0) begin
               if (!abort) chk("select_len", 32'(run), 32'd3);
               abort = 1'b0;
            end
            run = 0;
            gap++;
         end

         if (bus_if.cmd_ready) chk("idle_bus", 32'({rw, select == '0}), 32'b11);
      end
   end

   // ---------------- stimulus ----------------
   task automatic issue(input int periph, input logic [7:0] addr, input logic rwr,
                        input logic [31:0] wdata, input logic [31:0] edata,
                        input logic [2:0] esize, input logic eerr, input int lat);
      exp_t e;
      bit ok = 0;
      @(posedge clk_12MHz); #1;
      bus_if.cmd_valid  = 1'b1;
      bus_if.cmd_periph = 4'(periph);
      bus_if.cmd_addr   = addr;
      bus_if.cmd_rw     = rwr;
      bus_if.cmd_wdata  = wdata;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk_12MHz);
         if (bus_if.cmd_ready) begin ok = 1; break; end
      end
      if (!ok) begin
         chk("accept_timeout", 32'd1, 32'd0);
      end else begin
         e.data = edata; e.size = esize; e.err = eerr; e.lat = lat; e.acc = cyc;
         e.periph = periph; e.addr = addr; e.rwr = rwr; e.wdata = wdata;
         exp_q.push_back(e);
      end
      @(posedge clk_12MHz); #1;
      bus_if.cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk_12MHz);
         if (exp_q.size() == 0 && bus_if.cmd_ready) begin ok = 1; break; end
      end
      if (!ok) chk("idle_timeout", 32'd1, 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int sc;
      bit ok;
      for (int i = 0; i < 256; i++) begin
         p2_mem[i] = 8'h0;
         p5_mem[i] = 32'h0;
      end
      resetn            = 1'b0;
      bus_if.cmd_valid  = 1'b0;
      bus_if.cmd_periph = 4'h0;
      bus_if.cmd_addr   = 8'h0;
      bus_if.cmd_rw     = 1'b1;
      bus_if.cmd_wdata  = 32'h0;
      bus_if.rsp_ready  = 1'b1;

      repeat (3) @(posedge clk_12MHz);
      @(negedge clk_12MHz);
      chk("rst_select", 32'(select), 32'd0);
      chk("rst_rw", 32'(rw), 32'd1);
      chk("rst_addr", 32'(register_addr), 32'd0);
      chk("rst_rsp", {bus_if.rsp_valid, bus_if.rsp_error, bus_if.rsp_size, bus_if.rsp_data[26:0]}, 32'd0);
      chk("rst_rsp_data", bus_if.rsp_data, 32'd0);
      @(posedge clk_12MHz); #1;
      resetn = 1'b1;
      mon_en = 1'b1;
      @(negedge clk_12MHz);
      chk("rst_cmd_ready", 32'(bus_if.cmd_ready), 32'd1);

      // write 1-byte register, then read it back
      issue(2, 8'd1, 1'b0, 32'h55, 32'h0, 3'd1, 1'b0, 6);
      wait_idle();
      chk("model_p2_reg1", 32'(p2_mem[1]), 32'h55);
      issue(2, 8'd1, 1'b1, 32'h0, 32'h55, 3'd1, 1'b0, 6);
      wait_idle();

      // unmapped register: size 0 -> error, still strobed
      sc = strobe_cnt;
      issue(0, 8'd9, 1'b1, 32'h0, 32'h0, 3'd0, 1'b1, 6);
      wait_idle();
      chk("unmapped_strobed", 32'(strobe_cnt - sc), 32'd1);

      // invalid peripheral: immediate error, no bus activity
      sc = strobe_cnt;
      issue(12, 8'd4, 1'b1, 32'h0, 32'h0, 3'd0, 1'b1, 1);
      wait_idle();
      chk("invalid_no_strobe", 32'(strobe_cnt - sc), 32'd0);

      // 32-bit register write/read
      issue(5, 8'd3, 1'b0, 32'hA5A51234, 32'h0, 3'd4, 1'b0, 6);
      wait_idle();
      issue(5, 8'd3, 1'b1, 32'h0, 32'hA5A51234, 3'd4, 1'b0, 6);
      wait_idle();

      // 2-byte register returning a full 32-bit pattern
`ifdef REGBUS_MASTER_SIZEMASK_EN
      issue(3, 8'h10, 1'b1, 32'h0, 32'h0000BEEF, 3'd2, 1'b0, 6);
`else
      issue(3, 8'h10, 1'b1, 32'h0, 32'hDEADBEEF, 3'd2, 1'b0, 6);
`endif
      wait_idle();

      // response back-pressure with a second command pending
      bus_if.rsp_ready = 1'b0;
      issue(5, 8'd7, 1'b0, 32'h0BADF00D, 32'h0, 3'd4, 1'b0, 6);
      fork
         issue(5, 8'd7, 1'b1, 32'h0, 32'h0BADF00D, 3'd4, 1'b0, 6);
         begin
            ok = 0;
            for (int i = 0; i < 50; i++) begin
               @(negedge clk_12MHz);
               if (bus_if.rsp_valid) begin ok = 1; break; end
            end
            if (!ok) chk("bp_rsp_timeout", 32'd1, 32'd0);
            repeat (10) @(posedge clk_12MHz);
            #1 bus_if.rsp_ready = 1'b1;
         end
      join
      wait_idle();

      // reset in the 2nd strobe cycle of a write aborts it silently
      issue(2, 8'd5, 1'b0, 32'hAA, 32'h0, 3'd1, 1'b0, 6);
      ok = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_12MHz);
         if (select != '0) begin ok = 1; break; end
      end
      if (!ok) chk("abort_strobe_timeout", 32'd1, 32'd0);
      @(posedge clk_12MHz); #1;
      abort  = 1'b1;
      resetn = 1'b0;
      @(posedge clk_12MHz); #1;
      exp_q.delete();
      @(negedge clk_12MHz);
      chk("abort_select", 32'(select), 32'd0);
      chk("abort_rw", 32'(rw), 32'd1);
      chk("abort_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
      @(posedge clk_12MHz); #1;
      resetn = 1'b1;
      @(negedge clk_12MHz);
      chk("abort_cmd_ready", 32'(bus_if.cmd_ready), 32'd1);
      ok = 0;
      repeat (8) begin
         @(negedge clk_12MHz);
         if (bus_if.rsp_valid) ok = 1;
      end
      chk("abort_no_rsp", 32'(ok), 32'd0);

      // normal operation after the abort
      issue(2, 8'd1, 1'b1, 32'h0, 32'h55, 3'd1, 1'b0, 6);
      wait_idle();

      repeat (3) @(posedge clk_12MHz);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/regbus_master.md
Name: regbus_master

Overview:
- Initiator for the shared peripheral register bus (databus/reg_size/register_addr/rw/select).
- Takes single register read or write commands from the command layer and runs one bus transaction on one selected peripheral. Returns the read data, register size and error status.
- Sits between the command parser and all register-bus peripherals (arm axes, etc.). Drives one select line per peripheral.

Parameters:
NUM_PERIPH, 8, number of peripheral select lines (1..16).
HOLD_CYCLES, 3, clock cycles select is held high per transaction (min 2; values <2 treated as 2).

Ports:
clk_12MHz  input  1  system clock; all logic on rising edge.
resetn  input  1  synchronous reset, active-low.
cmd_valid  input  1  command present.
cmd_ready  output  1  master can accept a command (high only in IDLE).
cmd_periph  input  4  target peripheral index.
cmd_addr  input  8  register address.
cmd_rw  input  1  0 = write, 1 = read.
cmd_wdata  input  32  write data.
rsp_valid  output  1  response present.
rsp_ready  input  1  response consumed.
rsp_data  output  32  read data (0 for writes).
rsp_size  output  3  reg_size sampled from peripheral (bytes).
rsp_error  output  1  no such register (size 0) or invalid peripheral.
databus  inout  32  shared data bus; driven only during write transactions.
reg_size  input  3  tri-state size from the selected peripheral.
register_addr  output  8  register address to peripherals.
rw  output  1  bus direction, 0 = write, 1 = read.
select  output  NUM_PERIPH  one-hot peripheral select.

Behaviour:
- Reset (resetn low at an edge): state IDLE; select all 0; rw 1; register_addr 0; databus released (Z); rsp_valid 0; rsp_data/rsp_size/rsp_error 0; cmd_ready 1 from the first cycle after reset. Reset aborts any transaction in progress: select drops at that same edge and no response is produced.
- States: IDLE, SETUP, STROBE, RELEASE, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch periph/addr/rw/wdata.
  - If cmd_periph>=NUM_PERIPH, go directly to RESP with rsp_error=1, rsp_size=0, rsp_data=0. No bus activity.
  - Otherwise go to SETUP.
- SETUP (1 cycle):
  - register_addr and rw driven; select all 0.
  - If write, databus driven with wdata.
- STROBE (HOLD_CYCLES cycles):
  - select[periph]=1 and all others 0.
  - Address, rw and write data stay stable.
  - At the edge ending the last STROBE cycle, sample reg_size into rsp_size. If a read, also sample databus into rsp_data. Writes set rsp_data=0.
  - Set rsp_error=(reg_size==0).
  - Go to RELEASE.
- RELEASE (1 cycle):
  - select all 0; address/rw/write data held for hold time.
  - Then go to RESP and release databus.
- RESP:
  - rsp_valid=1; outputs stable until rsp_valid&rsp_ready. Then return to IDLE.
  - cmd_ready=0 throughout RESP.
- Latency: rsp_valid rises HOLD_CYCLES+3 cycles after the accept edge (6 at default). Invalid-periph commands respond 1 cycle after accept.
- Peripherals edge-detect select, so select is guaranteed low for at least 2 cycles (RELEASE+SETUP) between consecutive transactions.
- rw returns to 1 in IDLE so no peripheral sees a write with select low.
- The master never drives databus while rw=1 (no contention with a reading peripheral).

Optional Feature:
- Macro REGBUS_MASTER_SIZEMASK_EN.
- Defined: read data is masked to rsp_size bytes before capture. Size 1 keeps [7:0], size 2 keeps [15:0], size 3 keeps [23:0], size ≥4 keeps all 32 bits, size 0 gives 0. Upper bits are forced to 0.
- Undefined: all 32 databus bits are captured unmodified.

Test Plan:
- Write periph 2 addr 1 data 0x55 (peripheral model with 1-byte regs) -> select[2] high exactly 3 cycles; databus=0x00000055 and rw=0 throughout; model reg1=0x55; rsp_size=1, rsp_error=0, rsp_data=0; rsp_valid 6 cycles after accept.
- Read periph 2 addr 1 after the write -> databus not driven by master; rsp_data=0x55, rsp_size=1, rsp_error=0.
- Read periph 0 addr 9 (unmapped, size 0) -> rsp_error=1, rsp_size=0; select[0] pulsed 3 cycles.
- cmd_periph=12 with NUM_PERIPH=8 -> no select activity; rsp_error=1 one cycle after accept.
- Hold rsp_ready=0 for 10 cycles with a second cmd_valid pending -> response stable; cmd_ready=0; second command accepted only after the handshake, with ≥2 select-low cycles between strobes.
- Assert resetn=0 during the 2nd STROBE cycle of a write -> select all 0, databus Z, rw=1 next cycle; no rsp_valid; cmd_ready=1 after resetn returns high. With REGBUS_MASTER_SIZEMASK_EN, peripheral returning 0xDEADBEEF with size 2 -> rsp_data=0x0000BEEF.
